instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage directly upstream of the decoder. Holds the program counter and issues sequential word fetches to a synchronous instruction memory with fixed 1-cycle read latency. Buffers returned words with their PCs and presents them to the decoder over a valid/ready handshake. Redirects from execute (branch/jump targets) flush buffered and in-flight fetches.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset
- `BUF_DEPTH`, 2, fetch buffer entries (power of 2, ≥2); also the max of in-flight plus buffered fetches
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `imem_req`  out  1  fetch request; memory always accepts
- `imem_addr`  out  32  word address of request (current PC register)
- `imem_rdata`  in  32  read data, valid the cycle after an accepted `imem_req`
- `redirect_valid`  in  1  one-cycle pulse: load new PC
- `redirect_pc`  in  32  redirect target
- `instr_valid`  out  1  `instr`/`instr_pc` hold a valid fetched word
- `instr`  out  32  instruction word to decoder
- `instr_pc`  out  32  PC of `instr`
- `instr_ready`  in  1  decoder accepts; transfer when `instr_valid && instr_ready`
- `fault`  out  1  sticky misaligned-redirect fault (see Configuration)
- `fault_pc`  out  32  offending target (see Configuration)

## Operation
- **States:** `BOOT` → `RUN` (unconditional, 1 cycle). `RUN` → `HALT` on a misaligned redirect (macro only). `HALT` exits only on reset.
- **Reset values:**
  - `imem_req`=0, `imem_addr`=`RESET_PC`
  - `instr_valid`=0, `instr`=32'h0000_0013 (NOP), `instr_pc`=0
  - `fault`=0, `fault_pc`=0
  - buffer empty, in-flight flag clear, state `BOOT`
- **Issue rule (RUN, no redirect):** `imem_req`=1 when occupancy + inflight − pop < `BUF_DEPTH`, where pop = `instr_valid && instr_ready`.
  - On issue: PC += 4 (wraps modulo 2^32), in-flight flag set.
- **Capture:** a response arriving with the in-flight flag set is written to the buffer as {PC, `imem_rdata`}.
- **Full buffer:** no request is issued. Nothing is dropped or duplicated.
- **Empty buffer:** `instr_valid`=0. `instr`/`instr_pc` hold their last values.
- **Redirect (highest priority):**
  - PC ← `redirect_pc`, `imem_req`=0 that cycle.
  - Buffer flushed; a response arriving the next cycle is discarded.
- **Redirect and pop in the same cycle:** the pop is a completed transfer. All remaining entries are flushed.
- **Reset mid-operation:** reset values the following cycle; any in-flight response is discarded.

## Timing
- Reset deasserted at edge 0: cycle 0 = `BOOT`. Cycle 1: `imem_req`=1, `imem_addr`=`RESET_PC`. Cycle 2: data. Cycle 3: `instr_valid`=1.
- Request-to-valid latency: 2 cycles. Throughput: 1 instr/cycle with `instr_ready` held high.
- Redirect at cycle N: no request in N. Request to target in N+1. `instr_valid` with `instr_pc`=target in N+3. No pre-redirect PC is presented after N.
- All outputs are registered except `imem_req`, which is combinational from state, occupancy, pop and `redirect_valid`.

## Configuration
- **`FETCH_MISALIGN_TRAP_EN` defined:**
  - A redirect with `redirect_pc[1:0]` ≠ 0 sets `fault`=1 and `fault_pc`=`redirect_pc` the next cycle.
  - The buffer is flushed and the state goes to `HALT`: `imem_req`=0, `instr_valid`=0 until reset.
- **Undefined:**
  - `redirect_pc[1:0]` is forced to 0 (aligned down).
  - `fault`=0 and `fault_pc`=0 constantly.

## Structure
- Shared package `riscv_pkg` holds:
  - NOP constant 32'h0000_0013
  - default reset PC
  - fetch state enum (`BOOT`, `RUN`, `HALT`)
- Sub-module `fetch_buf`: synchronous FIFO of `BUF_DEPTH` × 64-bit {pc, instr} entries.
  - push, pop and flush inputs; count output; flush overrides push.

## Test plan
- **Boot:** `RESET_PC`=0, memory returns `addr ^ 32'hA5A5_0000`, ready=1 → `imem_addr` 0,4,8… from cycle 1; `instr_valid` from cycle 3 with `instr_pc`=0, `instr`=32'hA5A5_0000; one instr per cycle thereafter.
- **Backpressure:** `instr_ready`=0 for 5 cycles → at most 2 requests outstanding, `imem_req`=0 while full; on release the PCs continue with no gap or duplicate.
- **Redirect:** redirect to 32'h100 at cycle N with a fetch in flight → `imem_req`=0 at N, `imem_addr`=32'h100 at N+1, first valid PC is 32'h100 at N+3, no stale PC appears.
- **Redirect with pop:** redirect and pop in the same cycle → popped word counted once; next delivered `instr_pc` = target.
- **Misaligned redirect:** redirect to 32'h102 → with macro: `fault`=1 and `fault_pc`=32'h102 next cycle, `imem_req` stays 0 until reset. Without macro: fetch proceeds from 32'h100.
- **Reset mid-stream:** reset asserted mid-stream → next cycle every output at its reset value; the in-flight response is never delivered.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared fetch-side definitions: NOP encoding, default reset PC, fetch FSM
// states and the {pc, instr} payload carried through the fetch buffer.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Fetch buffer: shift-style synchronous FIFO whose entry 0 is the head
// register, so the presented word and its valid flag come straight from flops.
// Flush overrides push; on pop of the last entry the head keeps its old value.
module fetch_buf
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  fetch_entry_t     i_wdata,
  output fetch_entry_t     o_head,
  output logic             o_head_valid,
  output logic [CNT_W-1:0] o_count
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t     r_mem [DEPTH];
  logic [CNT_W-1:0] r_count;
  logic             r_valid;

  logic             w_pop;
  logic             w_push;
  logic [CNT_W-1:0] w_remain;
  logic [CNT_W-1:0] w_count_nxt;

  // Occupancy after this cycle's pop/push/flush
  always_comb begin
    w_pop       = i_pop && (r_count != '0);
    w_remain    = r_count - CNT_W'(w_pop);
    w_push      = i_push && !i_flush && (w_remain < CNT_W'(DEPTH));
    w_count_nxt = i_flush ? '0 : (w_remain + CNT_W'(w_push));
  end

  // Storage: shift on pop when more than one entry remains, write at tail
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[IDX_W'(i)] <= '{pc: '0, instr: NOP_INSTR};
      end
      r_count <= '0;
      r_valid <= 1'b0;
    end else begin
      if (w_pop && !i_flush && (r_count > CNT_W'(1))) begin
        for (int i = 0; i < int'(DEPTH) - 1; i++) begin
          r_mem[IDX_W'(i)] <= r_mem[IDX_W'(i + 1)];
        end
      end
      if (w_push) begin
        r_mem[IDX_W'(w_remain)] <= i_wdata;
      end
      r_count <= w_count_nxt;
      r_valid <= (w_count_nxt != '0);
    end
  end

  assign o_head       = r_mem[0];
  assign o_head_valid = r_valid;
  assign o_count      = r_count;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: sequential word fetch from a 1-cycle-latency
// instruction memory, buffered delivery to the decoder over valid/ready,
// redirect flush from execute.
// Optional: define FETCH_MISALIGN_TRAP_EN to trap misaligned redirect targets
// (sticky fault + HALT); otherwise targets are aligned down to a word.
module instr_fetch
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic        fault,
  output logic [31:0] fault_pc
);

  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  fetch_state_e     r_state;
  fetch_state_e     w_state_nxt;
  logic [31:0]      r_pc;
  logic [31:0]      r_req_pc;
  logic             r_inflight;

  logic             w_pop;
  logic             w_room;
  logic             w_take_redir;
  logic             w_flush;
  logic             w_misalign;
  logic [31:0]      w_redir_pc;
  logic [CNT_W-1:0] w_count;
  logic [SUM_W-1:0] w_outstanding;
  logic             w_head_valid;
  fetch_entry_t     w_head;
  fetch_entry_t     w_wdata;

  // Space check: buffered + in-flight words after this cycle's transfer
  assign w_pop         = instr_valid && instr_ready;
  assign w_outstanding = SUM_W'(w_count) + SUM_W'(r_inflight) - SUM_W'(w_pop);
  assign w_room        = (w_outstanding < SUM_W'(BUF_DEPTH));

`ifdef FETCH_MISALIGN_TRAP_EN
  assign w_misalign = (redirect_pc[1:0] != 2'b00);
  assign w_redir_pc = redirect_pc;
`else
  assign w_misalign = 1'b0;
  assign w_redir_pc = redirect_pc & 32'hFFFF_FFFC;
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, request issue and redirect acceptance
  always_comb begin
    w_state_nxt  = r_state;
    imem_req     = 1'b0;
    w_take_redir = 1'b0;
    w_flush      = 1'b0;
    case (r_state)
      BOOT: begin
        w_state_nxt  = RUN;
        w_take_redir = redirect_valid;
      end
      RUN: begin
        if (redirect_valid) begin
          w_take_redir = 1'b1;
        end else begin
          imem_req = w_room;
        end
      end
      HALT: begin
        w_state_nxt = HALT;
      end
      default: begin
        w_state_nxt = BOOT;
      end
    endcase
    if (w_take_redir) begin
      w_flush = 1'b1;
      if (w_misalign) begin
        w_state_nxt = HALT;
      end
    end
  end

  // PC, in-flight flag and the PC of the outstanding request
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc       <= RESET_PC;
      r_req_pc   <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= imem_req;
      if (w_take_redir) begin
        r_pc <= w_redir_pc;
      end else if (imem_req) begin
        r_req_pc <= r_pc;
        r_pc     <= r_pc + 32'd4;
      end
    end
  end

  assign imem_addr = r_pc;
  assign w_wdata   = '{pc: r_req_pc, instr: imem_rdata};

  fetch_buf #(
    .DEPTH (BUF_DEPTH),
    .CNT_W (CNT_W)
  ) u_fetch_buf (
    .clk          (clk),
    .reset        (reset),
    .i_push       (r_inflight),
    .i_pop        (w_pop),
    .i_flush      (w_flush),
    .i_wdata      (w_wdata),
    .o_head       (w_head),
    .o_head_valid (w_head_valid),
    .o_count      (w_count)
  );

  assign instr_valid = w_head_valid;
  assign instr       = w_head.instr;
  assign instr_pc    = w_head.pc;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic        r_fault;
  logic [31:0] r_fault_pc;

  // Sticky misaligned-redirect fault
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fault    <= 1'b0;
      r_fault_pc <= '0;
    end else if (w_take_redir && w_misalign) begin
      r_fault    <= 1'b1;
      r_fault_pc <= redirect_pc;
    end
  end

  assign fault    = r_fault;
  assign fault_pc = r_fault_pc;
`else
  assign fault    = 1'b0;
  assign fault_pc = '0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed vector table, hand-written misaligned
// redirect and mid-stream reset sequences, then random traffic against a
// transaction-level model (queue of requested PCs with their issue cycle).
// Honours FETCH_MISALIGN_TRAP_EN to pick the expected misaligned behaviour.
module tb_instr_fetch;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam int unsigned BUF_DEPTH = 2;
  localparam logic [31:0] MEM_KEY   = 32'hA5A5_0000;
  localparam logic [31:0] NOP       = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        fault;
  logic [31:0] fault_pc;

  instr_fetch #(
    .RESET_PC  (RESET_PC),
    .BUF_DEPTH (BUF_DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready),
    .fault          (fault),
    .fault_pc       (fault_pc)
  );

  always #5 clk = ~clk;

  // Memory: word at addr is addr ^ MEM_KEY one cycle after a request, junk otherwise
  always @(posedge clk) begin
    imem_rdata <= imem_req ? (imem_addr ^ MEM_KEY) : $urandom;
  end

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  typedef struct {
    logic [31:0] pc;
    int          cyc;
  } req_t;

  req_t        q[$];
  int          m_cyc = 0;
  int          m_age = 0;
  logic [31:0] m_pc;
  logic [31:0] m_last_pc;
  logic [31:0] m_last_instr;
  logic        m_halted;
  logic        m_fault;
  logic [31:0] m_fault_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, m_cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, m_cyc);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pc         = RESET_PC;
    m_age        = 0;
    m_halted     = 1'b0;
    m_last_pc    = 32'h0;
    m_last_instr = NOP;
    m_fault      = 1'b0;
    m_fault_pc   = 32'h0;
  endtask

  // Compare this cycle's outputs with the model, then advance it past the edge
  task automatic model_cycle();
    logic ev;
    logic pop;
    logic ereq;
    int   occ;
    ev = !m_halted && (q.size() > 0) && (q[0].cyc + 2 <= m_cyc);
    chk1("instr_valid", instr_valid, ev);
    if (ev) begin
      m_last_pc    = q[0].pc;
      m_last_instr = q[0].pc ^ MEM_KEY;
    end
    chk("instr_pc", instr_pc, m_last_pc);
    chk("instr", instr, m_last_instr);
    pop  = ev && instr_ready;
    occ  = q.size() - (pop ? 1 : 0);
    ereq = !m_halted && (m_age >= 1) && !redirect_valid && (occ < int'(BUF_DEPTH));
    chk1("imem_req", imem_req, ereq);
    if (!m_halted) chk("imem_addr", imem_addr, m_pc);
    chk1("fault", fault, m_fault);
    chk("fault_pc", fault_pc, m_fault_pc);
    if (reset) begin
      model_reset();
    end else begin
      if (pop) void'(q.pop_front());
      if (redirect_valid && !m_halted) begin
        q.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
        if (redirect_pc[1:0] != 2'b00) begin
          m_halted   = 1'b1;
          m_fault    = 1'b1;
          m_fault_pc = redirect_pc;
        end
        m_pc = redirect_pc;
`else
        m_pc = {redirect_pc[31:2], 2'b00};
`endif
      end else if (ereq) begin
        q.push_back('{pc: m_pc, cyc: m_cyc});
        m_pc = m_pc + 32'd4;
      end
      m_age++;
    end
    m_cyc++;
  endtask

  task automatic step(input logic rst, input logic rdy, input logic rv, input logic [31:0] rpc);
    @(negedge clk);
    reset          = rst;
    instr_ready    = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
    model_cycle();
  endtask

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic rdy, input logic rv,
                              input logic [31:0] rpc, input logic e_req,
                              input logic [31:0] e_addr, input logic e_valid,
                              input logic [31:0] e_pc, input logic [31:0] e_instr);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
    v.e_pc = e_pc; v.e_instr = e_instr;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    logic [31:0] rpc;
    reset          = 1'b1;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    model_reset();
    repeat (2) @(posedge clk);

    // Row 0: reset held; rows 1.. are cycles 0.. after reset release
    tbl.push_back(mk(1, 1, 0, 0, 0, 32'h00,  0, 32'h00,  NOP));
    tbl.push_back(mk(0, 1, 0, 0, 0, 32'h00,  0, 32'h00,  NOP));
    tbl.push_back(mk(0, 1, 0, 0, 1, 32'h00,  0, 32'h00,  NOP));
    tbl.push_back(mk(0, 1, 0, 0, 1, 32'h04,  0, 32'h00,  NOP));
    tbl.push_back(mk(0, 1, 0, 0, 1, 32'h08,  1, 32'h00,  MEM_KEY));
    tbl.push_back(mk(0, 1, 0, 0, 1, 32'h0C,  1, 32'h04,  MEM_KEY ^ 32'h04));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0, 0, 0, 0, 0, 32'h10, 1, 32'h08, MEM_KEY ^ 32'h08));
    tbl.push_back(mk(0, 1, 0, 0, 1, 32'h10,  1, 32'h08,  MEM_KEY ^ 32'h08));
    tbl.push_back(mk(0, 1, 0, 0, 1, 32'h14,  1, 32'h0C,  MEM_KEY ^ 32'h0C));
    tbl.push_back(mk(0, 1, 0, 0, 1, 32'h18,  1, 32'h10,  MEM_KEY ^ 32'h10));
    tbl.push_back(mk(0, 1, 0, 0, 1, 32'h1C,  1, 32'h14,  MEM_KEY ^ 32'h14));
    tbl.push_back(mk(0, 1, 1, 32'h100, 0, 32'h20, 1, 32'h18, MEM_KEY ^ 32'h18));
    tbl.push_back(mk(0, 1, 0, 0, 1, 32'h100, 0, 32'h18,  MEM_KEY ^ 32'h18));
    tbl.push_back(mk(0, 1, 0, 0, 1, 32'h104, 0, 32'h18,  MEM_KEY ^ 32'h18));
    tbl.push_back(mk(0, 1, 0, 0, 1, 32'h108, 1, 32'h100, MEM_KEY ^ 32'h100));
    tbl.push_back(mk(0, 1, 0, 0, 1, 32'h10C, 1, 32'h104, MEM_KEY ^ 32'h104));

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].rdy, tbl[i].rv, tbl[i].rpc);
      chk1("tbl_req", imem_req, tbl[i].e_req);
      chk("tbl_addr", imem_addr, tbl[i].e_addr);
      chk1("tbl_valid", instr_valid, tbl[i].e_valid);
      chk("tbl_pc", instr_pc, tbl[i].e_pc);
      chk("tbl_instr", instr, tbl[i].e_instr);
    end

    // Misaligned redirect to 0x102
    step(0, 1, 1, 32'h102);
    chk1("mis_req_n", imem_req, 1'b0);
`ifdef FETCH_MISALIGN_TRAP_EN
    step(0, 1, 0, 0);
    chk1("mis_fault", fault, 1'b1);
    chk("mis_fault_pc", fault_pc, 32'h102);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 1, 32'h40);
      chk1("halt_req", imem_req, 1'b0);
      chk1("halt_valid", instr_valid, 1'b0);
      chk1("halt_fault", fault, 1'b1);
    end
`else
    step(0, 1, 0, 0);
    chk1("mis_req", imem_req, 1'b1);
    chk("mis_addr", imem_addr, 32'h100);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    chk1("mis_valid", instr_valid, 1'b1);
    chk("mis_pc", instr_pc, 32'h100);
`endif

    // Reset mid-stream with a request in flight
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    chk1("rst_inflight_req", imem_req, 1'b1);
    step(0, 1, 0, 0);
    chk1("rst_req", imem_req, 1'b0);
    chk("rst_addr", imem_addr, RESET_PC);
    chk1("rst_valid", instr_valid, 1'b0);
    chk("rst_instr", instr, NOP);
    chk("rst_pc", instr_pc, 32'h0);
    chk1("rst_fault", fault, 1'b0);
    chk("rst_fault_pc", fault_pc, 32'h0);
    step(0, 1, 0, 0);
    chk1("rst_c1_valid", instr_valid, 1'b0);
    step(0, 1, 0, 0);
    chk1("rst_c2_valid", instr_valid, 1'b0);
    step(0, 1, 0, 0);
    chk1("rst_c3_valid", instr_valid, 1'b1);
    chk("rst_c3_pc", instr_pc, RESET_PC);
    chk("rst_c3_instr", instr, RESET_PC ^ MEM_KEY);

    // Redirect and pop in the same cycle with a full buffer
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    chk1("full_valid", instr_valid, 1'b1);
    chk1("full_req", imem_req, 1'b0);
    step(0, 1, 1, 32'h200);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    chk("redir_pop_pc", instr_pc, 32'h200);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      case ($urandom % 3)
        0:       rpc = $urandom;
        1:       rpc = 32'hFFFF_FFF0 | 32'($urandom % 16);
        default: rpc = 32'h100 + 32'($urandom % 64);
      endcase
`ifdef FETCH_MISALIGN_TRAP_EN
      rpc[1:0] = 2'b00;
`endif
      step(($urandom % 300) == 0, ($urandom % 4) != 0, ($urandom % 16) == 0, rpc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
